// File: rtl/suprloco_sram_pkg.sv
// Shared types and sizing helpers for the suprloco shared SRAM and its arbiter.
package suprloco_sram_pkg;

    // Channel-index width for the largest supported channel count (8).
    localparam int CH_IDX_W_MAX = $clog2(8);

    // Width of a channel index; a single channel still gets a 1-bit index.
    function automatic int ch_idx_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    function automatic int be_w(input int dw);
        return dw / 8;
    endfunction

    typedef enum logic {ST_RUN, ST_CLEAR} state_t;

endpackage

// File: rtl/suprloco_rr_arbiter.sv
// Combinational round-robin arbiter: priority starts one past ptr and wraps modulo CH.
module suprloco_rr_arbiter
    import suprloco_sram_pkg::*;
#(
    parameter int CH = 2,
    localparam int PW = ch_idx_w(CH)
) (
    input  logic [CH-1:0] req,
    input  logic [PW-1:0] ptr,
    output logic [CH-1:0] gnt,
    output logic [PW-1:0] idx,
    output logic          vld
);

    logic [PW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        vld  = 1'b0;
        cand = '0;
        for (int i = 1; i <= CH; i++) begin
            cand = PW'((int'(ptr) + i) % CH);
            if (!vld && req[cand]) begin
                vld       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/suprloco_sram_arb.sv
// Single-port SRAM shared by CH req/ack channels through a round-robin arbiter.
// Optional SUPRLOCO_SRAM_CLEAR_EN: zero the whole RAM after every reset before serving requests.
module suprloco_sram_arb
    import suprloco_sram_pkg::*;
#(
    parameter int    AW         = 10,
    parameter int    DW         = 8,
    parameter int    CH         = 2,
    parameter string simhexfile = ""
) (
    input  logic                   i_MCLK,
    input  logic                   i_RST,
    input  logic [CH-1:0]          i_REQ,
    input  logic [CH-1:0]          i_WE,
    input  logic [CH*AW-1:0]       i_ADDR,
    input  logic [CH*DW-1:0]       i_DIN,
    input  logic [CH*be_w(DW)-1:0] i_BE,
    output logic [CH-1:0]          o_ACK,
    output logic [DW-1:0]          o_DOUT,
    output logic                   o_BUSY
);

    localparam int PW    = ch_idx_w(CH);
    localparam int BW    = be_w(DW);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] addr_a [CH];
    logic [DW-1:0] din_a  [CH];
    logic [BW-1:0] be_a   [CH];

    logic [CH-1:0] elig, gnt, ack_p1;
    logic [PW-1:0] ptr, gidx;
    logic          gvld, run, clr_wr;
    logic [AW-1:0] clr_addr;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_din, old_word, merged, dout_p1;
    logic [BW-1:0] sel_be;
    logic          sel_we, acc_wr, acc_rd;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    for (genvar k = 0; k < CH; k++) begin : g_unpack
        assign addr_a[k] = i_ADDR[k*AW +: AW];
        assign din_a[k]  = i_DIN[k*DW +: DW];
        assign be_a[k]   = i_BE[k*BW +: BW];
    end

    // A channel is not eligible in its own ack cycle, so no request is served twice.
    assign elig = run ? (i_REQ & ~ack_p1) : '0;

    suprloco_rr_arbiter #(.CH(CH)) u_arb (
        .req (elig),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gidx),
        .vld (gvld)
    );

    assign sel_addr = addr_a[gidx];
    assign sel_din  = din_a[gidx];
    assign sel_be   = be_a[gidx];
    assign sel_we   = i_WE[gidx];
    assign old_word = mem[sel_addr];

    for (genvar b = 0; b < BW; b++) begin : g_lane
        assign merged[b*8 +: 8] = sel_be[b] ? sel_din[b*8 +: 8] : old_word[b*8 +: 8];
    end

    // A write granted while reset is sampled must leave the RAM untouched.
    assign acc_wr = gvld & sel_we & ~i_RST;
    assign acc_rd = gvld & ~sel_we;

    // ---- stage p1: RAM access, ack and read data ----
    always_ff @(posedge i_MCLK) begin
        if (clr_wr)      mem[clr_addr] <= '0;
        else if (acc_wr) mem[sel_addr] <= merged;
    end

    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            ack_p1  <= '0;
            ptr     <= PW'(CH - 1);
            dout_p1 <= '0;
        end else begin
            ack_p1 <= gnt;
            if (gvld)   ptr     <= gidx;
            if (acc_rd) dout_p1 <= mem[sel_addr];
        end
    end

    assign o_ACK  = ack_p1;
    assign o_DOUT = dout_p1;

`ifdef SUPRLOCO_SRAM_CLEAR_EN
    state_t        state, state_nx;
    logic [AW-1:0] clr_addr_nx;

    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nx;
            clr_addr <= clr_addr_nx;
        end
    end

    // One word zeroed per cycle once reset has released; RUN after the top address.
    always_comb begin
        state_nx    = state;
        clr_addr_nx = clr_addr;
        clr_wr      = 1'b0;
        if (state == ST_CLEAR) begin
            clr_wr      = ~i_RST;
            clr_addr_nx = clr_addr + 1'b1;
            if (clr_addr == '1) state_nx = ST_RUN;
        end
    end

    assign run    = (state == ST_RUN);
    assign o_BUSY = (state == ST_CLEAR);
`else
    assign run      = 1'b1;
    assign clr_wr   = 1'b0;
    assign clr_addr = '0;
    assign o_BUSY   = 1'b0;
`endif

endmodule
